regs_uart: RTL and testbench

- Register file and baud generator of a 16550-compatible UART.
- Decodes 3-bit CPU address/read/write strobes into the standard 16550 register map (DLAB-banked).
- Issues push/pop strobes to the external TX/RX FIFOs and generates the baud tick shared by TX and RX.
- Exports all register contents as one packed struct for the TX/RX engines.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/regs_uart.sv | 116 +++++++++++
 tb/tb_regs_uart.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map constants for the 16550 register block
package uart_pkg;

    typedef struct packed {
        logic [7:0] dll;
        logic [7:0] dlm;
        logic [7:0] ier;
        logic [7:0] iir;
        logic [7:0] fcr;
        logic [7:0] lcr;
        logic [7:0] mcr;
        logic [7:0] lsr;
        logic [7:0] msr;
        logic [7:0] scr;
    } csr_t;

    localparam logic [2:0] ADDR_THR_DLL = 3'd0;
    localparam logic [2:0] ADDR_IER_DLM = 3'd1;
    localparam logic [2:0] ADDR_FCR_IIR = 3'd2;
    localparam logic [2:0] ADDR_LCR     = 3'd3;
    localparam logic [2:0] ADDR_MCR     = 3'd4;
    localparam logic [2:0] ADDR_LSR     = 3'd5;
    localparam logic [2:0] ADDR_MSR     = 3'd6;
    localparam logic [2:0] ADDR_SCR     = 3'd7;

    localparam logic [7:0] IIR_NONE = 8'h01;
    localparam logic [7:0] IIR_THRE = 8'h02;
    localparam logic [7:0] IIR_RDA  = 8'h04;
    localparam logic [7:0] IIR_RLS  = 8'h06;

    // FCR keeps enable, DMA mode and trigger level; the reset bits self-clear
    localparam logic [7:0] FCR_STORE_MASK = 8'hC9;

    function automatic logic [3:0] rx_threshold(input logic [1:0] trig);
        case (trig)
            2'b00:   return 4'd1;
            2'b01:   return 4'd4;
            2'b10:   return 4'd8;
            default: return 4'd14;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - divisor-driven baud tick generator shared by TX and RX
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        reload,
    output logic        tick
);

    logic [15:0] count;

    // Reload parks the counter at zero so the first tick lands right after a divisor write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (divisor == 16'd0 || reload) begin
            count <= '0;
        end else if (count == 16'd0) begin
            count <= divisor - 16'd1;
        end else begin
            count <= count - 16'd1;
        end
    end

    assign tick = (divisor != 16'd0) && (count == 16'd0);

endmodule

// File: rtl/regs_uart.sv
// rtl/regs_uart.sv - 16550 register file, FIFO strobes, read mux and baud generator
module regs_uart
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic       rd_i,
    input  logic       rx_fifo_empty_i,
    input  logic       rx_oe,
    input  logic       rx_pe,
    input  logic       rx_fe,
    input  logic       rx_bi,
    input  logic [2:0] addr_i,
    input  logic [7:0] din_i,
    output logic       tx_push_o,
    output logic       rx_pop_o,
    output logic       baud_out,
    output logic       tx_rst,
    output logic       rx_rst,
    output logic [3:0] rx_fifo_threshold,
    output logic [7:0] dout_o,
    output csr_t       csr,
    input  logic [7:0] rx_fifo_in
);

    logic [7:0] dll, dlm, ier, fcr, lcr, mcr, scr;
    logic [7:0] lsr, iir;
    logic [3:0] err;
    logic       dlab, lsr_rd, div_reload;

    assign dlab       = lcr[7];
    assign lsr_rd     = rst & rd_i & ~wr_i & (addr_i == ADDR_LSR);
    assign tx_push_o  = rst & wr_i & (addr_i == ADDR_THR_DLL) & ~dlab;
    assign rx_pop_o   = rst & rd_i & ~wr_i & (addr_i == ADDR_THR_DLL) & ~dlab & ~rx_fifo_empty_i;
    assign div_reload = wr_i & dlab & ((addr_i == ADDR_THR_DLL) | (addr_i == ADDR_IER_DLM));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dll    <= '0;
            dlm    <= '0;
            ier    <= '0;
            fcr    <= '0;
            lcr    <= '0;
            mcr    <= '0;
            scr    <= '0;
            err    <= '0;
            tx_rst <= 1'b0;
            rx_rst <= 1'b0;
        end else begin
            tx_rst <= 1'b0;
            rx_rst <= 1'b0;
            // err holds {BI, FE, PE, OE}; a new pulse outranks the read clear
            err <= (lsr_rd ? 4'b0000 : err) | {rx_bi, rx_fe, rx_pe, rx_oe};
            if (wr_i) begin
                case (addr_i)
                    ADDR_THR_DLL: if (dlab) dll <= din_i;
                    ADDR_IER_DLM: begin
                        if (dlab) dlm <= din_i;
                        else      ier <= {4'b0000, din_i[3:0]};
                    end
                    ADDR_FCR_IIR: begin
                        fcr    <= din_i & FCR_STORE_MASK;
                        rx_rst <= din_i[1];
                        tx_rst <= din_i[2];
                    end
                    ADDR_LCR: lcr <= din_i;
                    ADDR_MCR: mcr <= {3'b000, din_i[4:0]};
                    ADDR_SCR: scr <= din_i;
                    default: ;
                endcase
            end
        end
    end

    // Bit 0 is gated by reset so the exported LSR shows its reset value while held
    assign lsr = {|err, 2'b11, err, rst & ~rx_fifo_empty_i};

    always_comb begin
        iir = IIR_NONE;
        if (ier[2] && err != 4'b0000)     iir = IIR_RLS;
        else if (ier[0] && lsr[0])        iir = IIR_RDA;
        else if (ier[1])                  iir = IIR_THRE;
        if (fcr[0]) iir[7:6] = 2'b11;
    end

    always_comb begin
        dout_o = 8'h00;
        if (rst) begin
            case (addr_i)
                ADDR_THR_DLL: dout_o = dlab ? dll : rx_fifo_in;
                ADDR_IER_DLM: dout_o = dlab ? dlm : ier;
                ADDR_FCR_IIR: dout_o = iir;
                ADDR_LCR:     dout_o = lcr;
                ADDR_MCR:     dout_o = mcr;
                ADDR_LSR:     dout_o = lsr;
                ADDR_MSR:     dout_o = 8'h00;
                default:      dout_o = scr;
            endcase
        end
    end

    assign rx_fifo_threshold = rx_threshold(fcr[7:6]);

    assign csr = '{dll: dll, dlm: dlm, ier: ier, iir: iir, fcr: fcr,
                   lcr: lcr, mcr: mcr, lsr: lsr, msr: 8'h00, scr: scr};

    uart_baud_gen u_baud (
        .clk     (clk),
        .rst     (rst),
        .divisor ({dlm, dll}),
        .reload  (div_reload),
        .tick    (baud_out)
    );

endmodule

// File: tb/tb_regs_uart.sv
// tb/tb_regs_uart.sv - scoreboard bench for regs_uart against a register-map reference model
module tb_regs_uart;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_i, rd_i, rx_fifo_empty_i;
    logic       rx_oe, rx_pe, rx_fe, rx_bi;
    logic [2:0] addr_i;
    logic [7:0] din_i, rx_fifo_in;
    logic       tx_push_o, rx_pop_o, baud_out, tx_rst, rx_rst;
    logic [3:0] rx_fifo_threshold;
    logic [7:0] dout_o;
    csr_t       csr;

    regs_uart dut (
        .clk               (clk),
        .rst               (rst),
        .wr_i              (wr_i),
        .rd_i              (rd_i),
        .rx_fifo_empty_i   (rx_fifo_empty_i),
        .rx_oe             (rx_oe),
        .rx_pe             (rx_pe),
        .rx_fe             (rx_fe),
        .rx_bi             (rx_bi),
        .addr_i            (addr_i),
        .din_i             (din_i),
        .tx_push_o         (tx_push_o),
        .rx_pop_o          (rx_pop_o),
        .baud_out          (baud_out),
        .tx_rst            (tx_rst),
        .rx_rst            (rx_rst),
        .rx_fifo_threshold (rx_fifo_threshold),
        .dout_o            (dout_o),
        .csr               (csr),
        .rx_fifo_in        (rx_fifo_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rd;
        logic [7:0] dout;
        logic       push;
        logic       pop;
        csr_t       csr;
        logic [3:0] thr;
    } exp_t;

    exp_t exp_q[$];
    int   tick_q[$];
    int   rxr_q[$];
    int   txr_q[$];

    logic [7:0] m_dll, m_dlm, m_ier, m_fcr, m_lcr, m_mcr, m_scr;
    logic [3:0] m_err;
    int         m_base;
    logic [3:0] thr_tab [4] = '{4'd1, 4'd4, 4'd8, 4'd14};
    int         last_tick = -1;
    int         tick_gap = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_dll = 8'h00; m_dlm = 8'h00; m_ier = 8'h00; m_fcr = 8'h00;
        m_lcr = 8'h00; m_mcr = 8'h00; m_scr = 8'h00; m_err = 4'h0;
        m_base = 0;
        tick_q.delete();
        rxr_q.delete();
        txr_q.delete();
    endtask

    function automatic logic [7:0] m_lsr(input logic empty);
        return {|m_err, 2'b11, m_err, ~empty};
    endfunction

    function automatic logic [7:0] m_iir(input logic empty);
        logic [7:0] v;
        if (m_ier[2] && m_err != 4'h0) v = 8'h06;
        else if (m_ier[0] && !empty)   v = 8'h04;
        else if (m_ier[1])             v = 8'h02;
        else                           v = 8'h01;
        if (m_fcr[0]) v = v | 8'hC0;
        return v;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a, input logic empty, input logic [7:0] fifo);
        case (a)
            3'd0:    return m_lcr[7] ? m_dll : fifo;
            3'd1:    return m_lcr[7] ? m_dlm : m_ier;
            3'd2:    return m_iir(empty);
            3'd3:    return m_lcr;
            3'd4:    return m_mcr;
            3'd5:    return m_lsr(empty);
            3'd6:    return 8'h00;
            default: return m_scr;
        endcase
    endfunction

    function automatic csr_t m_csr(input logic empty);
        csr_t c;
        c.dll = m_dll; c.dlm = m_dlm; c.ier = m_ier; c.iir = m_iir(empty);
        c.fcr = m_fcr; c.lcr = m_lcr; c.mcr = m_mcr; c.lsr = m_lsr(empty);
        c.msr = 8'h00; c.scr = m_scr;
        return c;
    endfunction

    // One bus cycle: drive, predict this cycle's outputs, then advance the model past the edge
    task automatic cycle(input logic w, input logic r, input logic [2:0] a, input logic [7:0] d,
                         input logic empty, input logic [7:0] fifo, input logic [3:0] pulses);
        exp_t e;
        int   div;
        logic dl;
        @(posedge clk);
        #1;
        wr_i = w; rd_i = r; addr_i = a; din_i = d;
        rx_fifo_empty_i = empty; rx_fifo_in = fifo;
        {rx_bi, rx_fe, rx_pe, rx_oe} = pulses;
        if (rst) begin
            dl  = m_lcr[7];
            div = int'({m_dlm, m_dll});
            if (div != 0 && cyc >= m_base && (cyc - m_base) % div == 0) tick_q.push_back(cyc);
            if (w || r) begin
                e.rd   = r;
                e.dout = m_read(a, empty, fifo);
                e.push = w && a == 3'd0 && !dl;
                e.pop  = r && !w && a == 3'd0 && !dl && !empty;
                e.csr  = m_csr(empty);
                e.thr  = thr_tab[m_fcr[7:6]];
                exp_q.push_back(e);
            end
            if (r && !w && a == 3'd5) m_err = 4'h0;
            m_err = m_err | pulses;
            if (w) begin
                case (a)
                    3'd0: if (dl) begin m_dll = d; m_base = cyc + 1; end
                    3'd1: if (dl) begin m_dlm = d; m_base = cyc + 1; end
                          else m_ier = d & 8'h0F;
                    3'd2: begin
                        m_fcr = d & 8'hC9;
                        if (d[1]) rxr_q.push_back(cyc + 1);
                        if (d[2]) txr_q.push_back(cyc + 1);
                    end
                    3'd3: m_lcr = d;
                    3'd4: m_mcr = d & 8'h1F;
                    3'd7: m_scr = d;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cycle(1'b1, 1'b0, a, d, 1'b1, 8'h00, 4'h0);
    endtask

    task automatic rd(input logic [2:0] a, input logic empty, input logic [7:0] fifo);
        cycle(1'b0, 1'b1, a, 8'h00, empty, fifo, 4'h0);
    endtask

    task automatic idle(input int n, input logic [3:0] pulses = 4'h0);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'h00, (k == 0) ? pulses : 4'h0);
    endtask

    task automatic ev(input string nm, input logic sig, ref int q[$]);
        if (sig) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL %s_spurious: got pulse expected none (cycle %0d)", nm, cyc);
            end else begin
                check(nm, 80'(cyc), 80'(q.pop_front()));
            end
        end
        while (q.size() > 0 && q[0] < cyc) begin
            tests++; fails++;
            $display("FAIL %s_missed: got none expected pulse at cycle %0d", nm, q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wr_i || rd_i) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL scoreboard_underflow: got access expected none (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.rd) check("dout", 80'(dout_o), 80'(e.dout));
                check("tx_push", 80'(tx_push_o), 80'(e.push));
                check("rx_pop", 80'(rx_pop_o), 80'(e.pop));
                check("csr", 80'(csr), 80'(e.csr));
                check("threshold", 80'(rx_fifo_threshold), 80'(e.thr));
            end
        end else begin
            check("idle_strobes", 80'({tx_push_o, rx_pop_o}), 80'(0));
        end
        if (baud_out) begin
            if (last_tick >= 0) tick_gap = cyc - last_tick;
            last_tick = cyc;
        end
        ev("baud", baud_out, tick_q);
        ev("rx_rst", rx_rst, rxr_q);
        ev("tx_rst", tx_rst, txr_q);
    end

    task automatic check_reset_state();
        csr_t r;
        r = '{dll: 8'h00, dlm: 8'h00, ier: 8'h00, iir: 8'h01, fcr: 8'h00,
              lcr: 8'h00, mcr: 8'h00, lsr: 8'h60, msr: 8'h00, scr: 8'h00};
        check("rst_csr", 80'(csr), 80'(r));
        check("rst_baud", 80'(baud_out), 80'(0));
        check("rst_dout", 80'(dout_o), 80'(0));
        check("rst_strobes", 80'({tx_push_o, rx_pop_o, tx_rst, rx_rst}), 80'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        wr_i = 1'b0; rd_i = 1'b0; addr_i = 3'd0; din_i = 8'h00;
        rx_fifo_empty_i = 1'b1; rx_fifo_in = 8'h00;
        {rx_bi, rx_fe, rx_pe, rx_oe} = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_reset_state();
        @(negedge clk);
        rst = 1'b1;

        // divisor 0x0108 = 264 cycles
        wr(3'd3, 8'h80);
        wr(3'd0, 8'h08);
        wr(3'd1, 8'h01);
        wr(3'd3, 8'h00);
        idle(600);
        @(negedge clk);
        check("div_dll", 80'(csr.dll), 80'(8'h08));
        check("div_dlm", 80'(csr.dlm), 80'(8'h01));
        check("div_lcr", 80'(csr.lcr), 80'(8'h00));
        check("baud_period", 80'(tick_gap), 80'(264));

        wr(3'd0, 8'h5A);
        rd(3'd0, 1'b0, 8'hC3);
        rd(3'd0, 1'b1, 8'hC3);

        wr(3'd2, 8'hC6);
        idle(2);
        @(negedge clk);
        check("fcr_stored", 80'(csr.fcr), 80'(8'hC0));
        check("fcr_threshold", 80'(rx_fifo_threshold), 80'(14));

        idle(1, 4'b0010);
        idle(3);
        @(negedge clk);
        check("lsr_pe_sticky", 80'(csr.lsr), 80'(8'hE4));
        rd(3'd5, 1'b1, 8'h00);
        rd(3'd5, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 3'd5, 8'h00, 1'b1, 8'h00, 4'b0100);
        idle(1);
        @(negedge clk);
        check("lsr_fe_over_clear", 80'(csr.lsr), 80'(8'hE8));
        rd(3'd5, 1'b1, 8'h00);

        wr(3'd1, 8'h05);
        rd(3'd2, 1'b0, 8'h00);
        idle(1, 4'b0001);
        rd(3'd2, 1'b0, 8'h00);
        rd(3'd5, 1'b0, 8'h00);
        wr(3'd1, 8'h00);
        rd(3'd2, 1'b0, 8'h00);
        idle(1);
        @(negedge clk);
        check("iir_none", 80'(csr.iir), 80'(8'h01));

        // reset in the middle of a divisor-4 count
        wr(3'd3, 8'h80);
        wr(3'd0, 8'h04);
        wr(3'd1, 8'h00);
        wr(3'd3, 8'h00);
        idle(9);
        @(posedge clk);
        #1;
        wr_i = 1'b0; rd_i = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_state();
        idle(4);
        @(negedge clk);
        rst = 1'b1;
        idle(40);

        for (int i = 0; i < 2500; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 3) == 0, 3'($urandom), 8'($urandom),
                  1'($urandom), 8'($urandom),
                  {($urandom % 16) == 0, ($urandom % 16) == 0, ($urandom % 16) == 0, ($urandom % 16) == 0});
        end
        idle(3);
        @(negedge clk);
        check("scoreboard_drained", 80'(exp_q.size()), 80'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
